// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round controller for elimination tic-tac-toe (board, per-player FIFOs, win check, scores).
// Optional macro TIMEOUT_LOSS_EN: a lone timeout in PLAY forfeits the round for the player to move.
`default_nettype none

module game_flow_ctrl #(
    parameter int MAX_MARKS = 3,
    parameter int SCORE_MAX = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_loc,
    input  logic [1:0]  move_mark,
    input  logic        timeout,
    input  logic        whos_turn,
    output logic [17:0] board,
    output logic [2:0]  state,
    output logic        accept_en,
    output logic [1:0]  winner,
    output logic [3:0]  score_x,
    output logic [3:0]  score_o
);

    localparam int PW = (MAX_MARKS + 1 > 1) ? $clog2(MAX_MARKS + 1) : 1;
    localparam int CW = $clog2(MAX_MARKS + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_ELIM  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t          r_state;
    logic [3:0]      r_fifo  [2][MAX_MARKS+1];
    logic [PW-1:0]   r_head  [2];
    logic [PW-1:0]   r_tail  [2];
    logic [CW-1:0]   r_count [2];
    logic            r_mover;           // 1: X made the last move, 0: O

    logic [1:0]      w_cell [9];
    logic [17:0]     w_tgt_bits;
    logic [1:0]      w_mover_mark;
    logic            w_legal;
    logic            w_push;
    logic            w_pidx;
    logic [CW-1:0]   w_push_count;
    logic [3:0]      w_head_loc;
    logic [17:0]     w_set_mask;
    logic [17:0]     w_clr_mask;
    logic            w_win;
    logic            w_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_MARKS)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'(SCORE_MAX)) ? s : s + 4'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_cell[i] = board[2*i +: 2];
        end
    end

    assign w_tgt_bits   = board >> {move_loc, 1'b0};
    assign w_legal      = move_valid && (move_loc <= 4'd8) &&
                          (move_mark == 2'b10 || move_mark == 2'b01) &&
                          (w_tgt_bits[1:0] == 2'b00);
    assign w_push       = (r_state == S_PLAY) && w_legal;
    assign w_pidx       = (move_mark == 2'b10);
    assign w_push_count = r_count[w_pidx] + CW'(1);
    assign w_mover_mark = r_mover ? 2'b10 : 2'b01;
    assign w_head_loc   = r_fifo[r_mover][r_head[r_mover]];
    assign w_set_mask   = {16'b0, move_mark} << {move_loc, 1'b0};
    assign w_clr_mask   = 18'b11 << {w_head_loc, 1'b0};

    // Eight lines evaluated only for the mark that just moved.
    always_comb begin
        w_win = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (w_cell[3*r] == w_mover_mark && w_cell[3*r+1] == w_mover_mark &&
                w_cell[3*r+2] == w_mover_mark) w_win = 1'b1;
            if (w_cell[r] == w_mover_mark && w_cell[r+3] == w_mover_mark &&
                w_cell[r+6] == w_mover_mark) w_win = 1'b1;
        end
        if (w_cell[0] == w_mover_mark && w_cell[4] == w_mover_mark &&
            w_cell[8] == w_mover_mark) w_win = 1'b1;
        if (w_cell[2] == w_mover_mark && w_cell[4] == w_mover_mark &&
            w_cell[6] == w_mover_mark) w_win = 1'b1;
    end

    always_comb begin
        w_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (w_cell[i] == 2'b00) w_full = 1'b0;
        end
    end

`ifndef TIMEOUT_LOSS_EN
    logic w_unused;
    assign w_unused = &{1'b0, timeout, whos_turn};
`endif

    // FIFO storage needs no reset: entries are only read below the live count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[w_pidx][r_tail[w_pidx]] <= move_loc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            board     <= '0;
            accept_en <= 1'b0;
            winner    <= 2'b00;
            score_x   <= 4'd0;
            score_o   <= 4'd0;
            r_mover   <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                r_head[p]  <= '0;
                r_tail[p]  <= '0;
                r_count[p] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        board     <= '0;
                        winner    <= 2'b00;
                        r_state   <= S_PLAY;
                        accept_en <= 1'b1;
                        for (int p = 0; p < 2; p++) begin
                            r_head[p]  <= '0;
                            r_tail[p]  <= '0;
                            r_count[p] <= '0;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_legal) begin
                        board            <= board | w_set_mask;
                        r_mover          <= w_pidx;
                        r_tail[w_pidx]   <= ptr_inc(r_tail[w_pidx]);
                        r_count[w_pidx]  <= w_push_count;
                        accept_en        <= 1'b0;
                        r_state          <= (w_push_count > CW'(MAX_MARKS)) ? S_ELIM : S_CHECK;
                    end
`ifdef TIMEOUT_LOSS_EN
                    else if (timeout && !move_valid) begin
                        accept_en <= 1'b0;
                        r_state   <= S_OVER;
                        if (whos_turn) begin
                            winner  <= 2'b01;
                            score_o <= sat_inc(score_o);
                        end else begin
                            winner  <= 2'b10;
                            score_x <= sat_inc(score_x);
                        end
                    end
`endif
                end
                S_ELIM: begin
                    board            <= board & ~w_clr_mask;
                    r_head[r_mover]  <= ptr_inc(r_head[r_mover]);
                    r_count[r_mover] <= r_count[r_mover] - CW'(1);
                    r_state          <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_win) begin
                        winner  <= w_mover_mark;
                        r_state <= S_OVER;
                        if (r_mover) score_x <= sat_inc(score_x);
                        else         score_o <= sat_inc(score_o);
                    end else if (w_full) begin
                        winner  <= 2'b00;
                        r_state <= S_OVER;
                    end else begin
                        r_state   <= S_PLAY;
                        accept_en <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    accept_en <= 1'b0;
                end
            endcase
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire
